// File: rtl/vga_pkg.sv
// Shared types and display-derived limits for the position path.
// The clamp limits default to the active area of the VGA timing.
package vga_pkg;

    localparam int unsigned HOR_ACTIVE = 800;
    localparam int unsigned VER_ACTIVE = 600;
    localparam int unsigned X_MAX_DEF  = HOR_ACTIVE - 1;
    localparam int unsigned Y_MAX_DEF  = VER_ACTIVE - 1;

    localparam int unsigned POS_XW = 12;
    localparam int unsigned POS_YW = 12;

    typedef logic [POS_XW-1:0] pos_x_t;
    typedef logic [POS_YW-1:0] pos_y_t;

    typedef enum logic {
        SRC_MOUSE = 1'b0,
        SRC_UART  = 1'b1
    } src_t;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        COMMIT
    } arb_state_t;

    // Round-robin choice: a lone requester wins; on a tie the one not granted last wins.
    function automatic src_t rr_pick(input logic m_pend, input logic u_pend, input src_t last);
        if (m_pend && u_pend) begin
            return (last == SRC_MOUSE) ? SRC_UART : SRC_MOUSE;
        end
        return u_pend ? SRC_UART : SRC_MOUSE;
    endfunction

endpackage

// File: rtl/pos_hold_reg.sv
// One-entry holding register for a position request: valid/ready capture,
// coordinate clamp and a pending flag that the arbiter clears on commit.
module pos_hold_reg #(
    parameter int unsigned XW    = 12,
    parameter int unsigned YW    = 12,
    parameter int unsigned X_MAX = 799,
    parameter int unsigned Y_MAX = 599
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    output logic          ready,
    input  logic [XW-1:0] xin,
    input  logic [YW-1:0] yin,
    input  logic          clr,
    output logic          pend,
    output logic [XW-1:0] xout,
    output logic [YW-1:0] yout
);

    localparam logic [XW-1:0] XCAP = XW'(X_MAX);
    localparam logic [YW-1:0] YCAP = YW'(Y_MAX);

    assign ready = !pend;

    // clr only arrives while pend is set, so it never collides with a capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            xout <= '0;
            yout <= '0;
        end else if (clr) begin
            pend <= 1'b0;
        end else if (valid && !pend) begin
            pend <= 1'b1;
            xout <= (xin > XCAP) ? XCAP : xin;
            yout <= (yin > YCAP) ? YCAP : yin;
        end
    end

endmodule

// File: rtl/pos_update_arbiter.sv
// Arbitrates mouse and UART position requests round-robin and commits the
// winner once per frame at the start of vertical blanking.
module pos_update_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned XW    = 12,
    parameter int unsigned YW    = 12,
    parameter int unsigned X_MAX = X_MAX_DEF,
    parameter int unsigned Y_MAX = Y_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vblnk,
    input  logic          m_valid,
    output logic          m_ready,
    input  logic [XW-1:0] m_xpos,
    input  logic [YW-1:0] m_ypos,
    input  logic          u_valid,
    output logic          u_ready,
    input  logic [XW-1:0] u_xpos,
    input  logic [YW-1:0] u_ypos,
    output logic [XW-1:0] xpos,
    output logic [YW-1:0] ypos,
    output logic          src,
    output logic          update,
    output logic [15:0]   frame_cnt
);

    arb_state_t    state;
    src_t          last_grant;
    src_t          win;
    src_t          pick;
    logic          vblnk_q;
    logic          vb_rise;
    logic          m_pend, u_pend;
    logic          m_clr, u_clr;
    logic [XW-1:0] m_x, u_x;
    logic [YW-1:0] m_y, u_y;

    pos_hold_reg #(.XW(XW), .YW(YW), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_mouse_hold (
        .clk   (clk),
        .rst   (rst),
        .valid (m_valid),
        .ready (m_ready),
        .xin   (m_xpos),
        .yin   (m_ypos),
        .clr   (m_clr),
        .pend  (m_pend),
        .xout  (m_x),
        .yout  (m_y)
    );

    pos_hold_reg #(.XW(XW), .YW(YW), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_uart_hold (
        .clk   (clk),
        .rst   (rst),
        .valid (u_valid),
        .ready (u_ready),
        .xin   (u_xpos),
        .yin   (u_ypos),
        .clr   (u_clr),
        .pend  (u_pend),
        .xout  (u_x),
        .yout  (u_y)
    );

    assign vb_rise = vblnk && !vblnk_q;
    assign pick    = rr_pick(m_pend, u_pend, last_grant);
    assign m_clr   = (state == COMMIT) && (win == SRC_MOUSE);
    assign u_clr   = (state == COMMIT) && (win == SRC_UART);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SRC_UART;
            win        <= SRC_MOUSE;
            xpos       <= '0;
            ypos       <= '0;
            src        <= 1'b0;
            update     <= 1'b0;
            frame_cnt  <= '0;
            // Track the live level so a reset inside blanking does not fake an edge
            vblnk_q    <= vblnk;
        end else begin
            vblnk_q <= vblnk;
            update  <= 1'b0;
            if (vb_rise) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (vb_rise) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    // Outputs load on leaving ARB so they are visible throughout COMMIT
                    if (m_pend || u_pend) begin
                        win        <= pick;
                        last_grant <= pick;
                        xpos       <= (pick == SRC_UART) ? u_x : m_x;
                        ypos       <= (pick == SRC_UART) ? u_y : m_y;
                        src        <= pick;
                        update     <= 1'b1;
                        state      <= COMMIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
